// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: assembles WIDTH-bit words LSB first and hands
// them off through a single-entry valid/ready output register with overflow.
module sipo_deframer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sync_clr,
  input  logic             par_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             complete;
  logic             handoff;
  logic             load;
  logic             drop;

  always_comb begin
    accept   = ser_valid & ~sync_clr;
    complete = accept & (cnt == LAST);
    handoff  = par_valid & par_ready;
    load     = complete & (~par_valid | handoff);
    drop     = complete & par_valid & ~par_ready;
    // New bits enter at the MSB so the first bit of a word lands in bit 0.
    word     = {ser_in, shreg[WIDTH-1:1]};
  end

  assign busy = (cnt != '0);

  // Assembly stage: bit counter and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (sync_clr) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (accept) begin
      shreg <= word;
      cnt   <= complete ? '0 : cnt + 1'b1;
    end
  end

  // Output stage: held word, its valid, and the sticky drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_out   <= '0;
      par_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        par_out   <= word;
        par_valid <= 1'b1;
      end else if (handoff) begin
        par_valid <= 1'b0;
      end
      // A drop on the same edge as a clear request keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer (WIDTH=4): a bit-position model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_sipo_deframer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         sync_clr = 1'b0;
  logic         par_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         busy;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  sipo_deframer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .sync_clr  (sync_clr),
    .par_ready (par_ready),
    .ovf_clr   (ovf_clr),
    .par_out   (par_out),
    .par_valid (par_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Model: bits are placed by position index into a word; a full word is
  // offered to a one-entry output slot.
  int           m_cnt = 0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_out = '0;
  bit           m_pv = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_done;
  bit           m_hand;
  logic [W-1:0] m_word;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_acc = '0; m_out = '0; m_pv = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      m_word = '0;
      m_hand = m_pv && par_ready;
      if (sync_clr) begin
        m_cnt = 0;
        m_acc = '0;
      end else if (ser_valid) begin
        m_acc[m_cnt] = ser_in;
        m_cnt = m_cnt + 1;
        if (m_cnt == W) begin
          m_done = 1'b1;
          m_word = m_acc;
          m_cnt = 0;
          m_acc = '0;
        end
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (m_done) begin
        if (!m_pv || m_hand) begin
          m_out = m_word;
          m_pv = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_hand) begin
        m_pv = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_par_out", 32'(par_out), 32'(m_out));
    chk("model_par_valid", 32'(par_valid), 32'(m_pv));
    chk("model_busy", 32'(busy), 32'(m_cnt != 0));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
  end

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit sv, input bit si, input bit sc, input bit pr, input bit oc);
    ser_valid = sv; ser_in = si; sync_clr = sc; par_ready = pr; ovf_clr = oc;
    @(posedge clk);
    #1;
    ser_valid = 1'b0; ser_in = 1'b0; sync_clr = 1'b0; par_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic bit_in(input bit b);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    @(posedge clk); #1;
    chk("reset_par_out", 32'(par_out), 32'h0);
    chk("reset_par_valid", 32'(par_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // First word 1,1,0,1 with no consumer
    bit_in(1); bit_in(1); bit_in(0);
    chk("w1_busy_mid", 32'(busy), 32'h1);
    bit_in(1);
    chk("w1_par_out", 32'(par_out), 32'hB);
    chk("w1_par_valid", 32'(par_valid), 32'h1);
    chk("w1_busy", 32'(busy), 32'h0);

    // Dropped word 0110 while 1011 is held
    bit_in(0); bit_in(1); bit_in(1); bit_in(0);
    chk("drop_par_out", 32'(par_out), 32'hB);
    chk("drop_overflow", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'h0);
    chk("ovf_clr_hold", 32'(par_out), 32'hB);

    // Handoff coinciding with completion of 0101
    bit_in(1); bit_in(0); bit_in(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("same_edge_par_out", 32'(par_out), 32'h5);
    chk("same_edge_par_valid", 32'(par_valid), 32'h1);
    chk("same_edge_overflow", 32'(overflow), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("handoff_clears_valid", 32'(par_valid), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ready_idle_no_effect", 32'(par_valid), 32'h0);

    // Gapped word 1,0 ... 0,1; ser_in noise during the gap is ignored
    bit_in(1); bit_in(0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("gap_busy", 32'(busy), 32'h1);
    end
    bit_in(0); bit_in(1);
    chk("gap_par_out", 32'(par_out), 32'h9);
    chk("gap_par_valid", 32'(par_valid), 32'h1);

    // Drop coinciding with ovf_clr: the set wins
    bit_in(1); bit_in(1); bit_in(1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("set_wins_overflow", 32'(overflow), 32'h1);
    chk("set_wins_par_out", 32'(par_out), 32'h9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear_and_consume_ovf", 32'(overflow), 32'h0);
    chk("clear_and_consume_valid", 32'(par_valid), 32'h0);

    // sync_clr discards a partial word and the bit on its edge
    bit_in(1); bit_in(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_clr_busy", 32'(busy), 32'h0);
    chk("sync_clr_valid", 32'(par_valid), 32'h0);
    bit_in(0); bit_in(0); bit_in(1); bit_in(1);
    chk("sync_clr_par_out", 32'(par_out), 32'hC);
    chk("sync_clr_par_valid", 32'(par_valid), 32'h1);

    // Asynchronous reset mid-word with a held word
    bit_in(1); bit_in(1); bit_in(1);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_par_out", 32'(par_out), 32'h0);
    chk("async_par_valid", 32'(par_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_overflow", 32'(overflow), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    bit_in(0); bit_in(1); bit_in(0);
    chk("post_reset_busy", 32'(busy), 32'h1);
    bit_in(0);
    chk("post_reset_par_out", 32'(par_out), 32'h2);
    chk("post_reset_par_valid", 32'(par_valid), 32'h1);
    chk("post_reset_busy_done", 32'(busy), 32'h0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, setting the parallel word width in bits; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ser_in, input, 1 bit: serial data bit, LSB of the word first.
REQ-005 The block SHALL have port ser_valid, input, 1 bit: ser_in is sampled on a rising clk edge only when ser_valid=1.
REQ-006 The block SHALL have port sync_clr, input, 1 bit: synchronous discard of the partially assembled word.
REQ-007 The block SHALL have port par_ready, input, 1 bit: the downstream consumer accepts par_out.
REQ-008 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of overflow.
REQ-009 The block SHALL have port par_out, output, WIDTH bits: the assembled word, registered.
REQ-010 The block SHALL have port par_valid, output, 1 bit: par_out holds an unconsumed word.
REQ-011 The block SHALL have port busy, output, 1 bit: a partial word is in progress (bit count nonzero).
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag indicating that a completed word was dropped.

Function
REQ-013 An accepted bit (ser_valid=1, sync_clr=0) SHALL shift into the assembly register so that the first accepted bit of a word ends at par_out[0] and the WIDTH-th ends at par_out[WIDTH-1].
REQ-014 A bit counter SHALL run 0..WIDTH-1, increment on each accepted bit, and wrap to 0 on the WIDTH-th accepted bit.
REQ-015 The counter and assembly register SHALL hold when ser_valid=0; gaps of any length between bits are legal.
REQ-016 busy SHALL equal (counter != 0).
REQ-017 On the edge that accepts the WIDTH-th bit, the complete word SHALL be loaded into par_out and par_valid set to 1 (zero added latency: visible immediately after that edge).
REQ-018 A handoff occurs on any edge where par_valid=1 and par_ready=1; par_valid SHALL then clear unless a new word completes on the same edge.
REQ-019 If a word completes on the same edge as a handoff, par_out SHALL load the new word, par_valid SHALL remain 1, and overflow SHALL NOT set.
REQ-020 If a word completes while par_valid=1 and par_ready=0, the new word SHALL be dropped, par_out SHALL keep the old word, and overflow SHALL set to 1.
REQ-021 par_out SHALL remain stable whenever par_valid=1 and no handoff occurs; par_ready while par_valid=0 SHALL have no effect.
REQ-022 When sync_clr=1, the counter and assembly register SHALL clear to 0 and any ser_in on that edge SHALL be discarded; par_out, par_valid and overflow SHALL be unaffected.
REQ-023 overflow SHALL clear on ovf_clr=1; if a set (REQ-020) and ovf_clr coincide, the set SHALL win.
REQ-024 The counter width SHALL be ceil(log2(WIDTH)) bits, and no other arithmetic SHALL be performed.

Reset
REQ-025 When rst=0, the block SHALL asynchronously drive par_out=0, par_valid=0, busy=0 and overflow=0, and clear the counter and assembly register.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after rst rises, the next accepted bit SHALL be bit 0 of a new word.
REQ-027 Reset asserted while par_valid=1 SHALL discard the held word with no handoff.

Verification (WIDTH=4)
REQ-028 Release rst, then present ser_valid=1 with bits 1,1,0,1 on consecutive edges and par_ready=0 -> after the 4th edge par_out=4'b1011, par_valid=1, busy=0.
REQ-029 Present bits 1,0 with ser_valid=1, hold ser_valid=0 for 3 cycles, then present 0,1 -> par_out=4'b1001 after the last bit, and busy=1 throughout the gap.
REQ-030 With par_valid=1 holding 4'b1011 and par_ready=0, complete word 4'b0110 -> par_out stays 4'b1011 and overflow=1; then pulse ovf_clr -> overflow=0.
REQ-031 With par_valid=1, assert par_ready on the same edge that completes 4'b0101 -> par_out=4'b0101, par_valid=1, overflow=0.
REQ-032 Present 2 bits, then sync_clr=1 with ser_valid=1, then 4 bits 0,0,1,1 -> busy=0 after the clear edge and par_out=4'b1100.
REQ-033 Drop rst after 3 accepted bits while par_valid=1 -> all outputs are 0 immediately, without waiting for a clock edge; after release, 4 new bits form a clean word.
